// File: rtl/intt_coeff_loader.sv
// INTT coefficient loader: streams N_COEFF coefficients into the INTT core, then starts it.
// Optional `INTT_LOADER_MODRED_EN adds a conditional subtract of Q on each coefficient.
module intt_coeff_loader #(
  parameter int DATA_W  = 27,
  parameter int N_COEFF = 1024
`ifdef INTT_LOADER_MODRED_EN
  ,
  parameter logic [DATA_W-1:0] Q = DATA_W'(27'h7fe0001)
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              load_data_intt,
  output logic [DATA_W-1:0] din_intt,
  output logic              start_intt,
  input  logic              done_intt,
  output logic              busy,
  output logic              job_done
);

  localparam int CNT_W = $clog2(N_COEFF);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_COEFF - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    BUSY,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ld_q, ld_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] coef;

`ifdef INTT_LOADER_MODRED_EN
  always_comb begin
    coef = (s_data >= Q) ? s_data - Q : s_data;
  end
`else
  always_comb begin
    coef = s_data;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_d       = 1'b0;
    din_d      = din_q;
    s_ready    = 1'b0;
    start_intt = 1'b0;
    job_done   = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          ld_d  = 1'b1;
          din_d = coef;
          if (cnt_q == LAST) begin
            state_d = START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: begin
        // last strobe is registered, so it lands in this same cycle
        start_intt = 1'b1;
        state_d    = BUSY;
      end
      BUSY: begin
        if (done_intt) state_d = DONE;
      end
      DONE: begin
        job_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      din_q   <= din_d;
    end
  end

  assign load_data_intt = ld_q;
  assign din_intt       = din_q;

endmodule
